uart_command_assembler: RTL and testbench

UART_COMMAND_ASSEMBLER -- requirements
Module: uart_command_assembler

---
 rtl/uart_command_assembler_pkg.sv | 22 ++
 rtl/uart_command_assembler_if.sv | 21 ++
 rtl/uart_command_assembler_timer.sv | 24 ++
 rtl/uart_command_assembler.sv | 80 ++++++++
 tb/tb_uart_command_assembler.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_command_assembler_pkg.sv
// Shared command definitions: FSM encodings, default limits and the command record.
package uart_command_assembler_pkg;

  localparam int         TIMEOUT_CLOCKS_DEF   = 8680;
  localparam logic [7:0] MAX_REQUEST_CODE_DEF = 8'h06;
  localparam logic [7:0] MAX_ADDRESS_DEF      = 8'h1F;

  localparam logic [1:0] ST_WAIT_CODE = 2'd0;
  localparam logic [1:0] ST_WAIT_ADDR = 2'd1;
  localparam logic [1:0] ST_CHECK     = 2'd2;
  localparam logic [1:0] ST_PENDING   = 2'd3;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] addr;
  } cmd_t;

  function automatic logic cmd_legal(cmd_t c, logic [7:0] max_code, logic [7:0] max_addr);
    return (c.code <= max_code) && (c.addr <= max_addr);
  endfunction

endpackage

// File: rtl/uart_command_assembler_if.sv
// Byte-in / command-out signal bundle between UART receiver, assembler and consumer.
interface uart_command_assembler_if;
  logic       has_data;
  logic [7:0] data_received;
  logic       command_ready;
  logic       command_valid;
  logic [7:0] request_code;
  logic [7:0] sensor_address;
  logic       frame_error;
  logic       overrun;

  modport master (
    output has_data, data_received, command_ready,
    input  command_valid, request_code, sensor_address, frame_error, overrun
  );

  modport slave (
    input  has_data, data_received, command_ready,
    output command_valid, request_code, sensor_address, frame_error, overrun
  );
endinterface

// File: rtl/uart_command_assembler_timer.sv
// Inter-byte timer: saturating up-counter, expired once TIMEOUT_CLOCKS-1 is reached.
module inter_byte_timer #(
  parameter int TIMEOUT_CLOCKS = 8680
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int           W    = (TIMEOUT_CLOCKS > 1) ? $clog2(TIMEOUT_CLOCKS) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CLOCKS - 1);

  logic [W-1:0] count;

  assign expired = (count == LAST);

  // Holding at LAST keeps the counter from wrapping if the FSM lingers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    count <= '0;
    else if (clear)               count <= '0;
    else if (enable && !expired)  count <= count + W'(1);
  end
endmodule

// File: rtl/uart_command_assembler.sv
// Assembles two UART bytes (code, address) into a range-checked command with ready/valid hand-off.
module uart_command_assembler
  import uart_command_assembler_pkg::*;
#(
  parameter int         TIMEOUT_CLOCKS   = uart_command_assembler_pkg::TIMEOUT_CLOCKS_DEF,
  parameter logic [7:0] MAX_REQUEST_CODE = uart_command_assembler_pkg::MAX_REQUEST_CODE_DEF,
  parameter logic [7:0] MAX_ADDRESS      = uart_command_assembler_pkg::MAX_ADDRESS_DEF
) (
  input logic                     clock,
  input logic                     reset,
  uart_command_assembler_if.slave bus
);
  logic [1:0] state;
  cmd_t       cmd;
  logic       take_code;
  logic       timer_enable;
  logic       timer_expired;

  // A code byte is accepted when idle, or when it arrives on the handshake edge.
  assign take_code    = bus.has_data &&
                        ((state == ST_WAIT_CODE) || (state == ST_PENDING && bus.command_ready));
  assign timer_enable = (state == ST_WAIT_ADDR) && !bus.has_data;

  inter_byte_timer #(.TIMEOUT_CLOCKS(TIMEOUT_CLOCKS)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (take_code),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= ST_WAIT_CODE;
      cmd                <= '0;
      bus.command_valid  <= 1'b0;
      bus.request_code   <= 8'h00;
      bus.sensor_address <= 8'h00;
      bus.frame_error    <= 1'b0;
      bus.overrun        <= 1'b0;
    end else begin
      bus.frame_error <= 1'b0;
      bus.overrun     <= 1'b0;
      if (take_code) cmd.code <= bus.data_received;
      case (state)
        ST_WAIT_CODE: if (bus.has_data) state <= ST_WAIT_ADDR;
        ST_WAIT_ADDR: begin
          if (bus.has_data) begin
            cmd.addr <= bus.data_received;
            state    <= ST_CHECK;
          end else if (timer_expired) begin
            bus.frame_error <= 1'b1;
            state           <= ST_WAIT_CODE;
          end
        end
        ST_CHECK: begin
          bus.overrun <= bus.has_data;
          if (cmd_legal(cmd, MAX_REQUEST_CODE, MAX_ADDRESS)) begin
            bus.request_code   <= cmd.code;
            bus.sensor_address <= cmd.addr;
            bus.command_valid  <= 1'b1;
            state              <= ST_PENDING;
          end else begin
            bus.frame_error <= 1'b1;
            state           <= ST_WAIT_CODE;
          end
        end
        ST_PENDING: begin
          if (bus.command_ready) begin
            bus.command_valid <= 1'b0;
            state             <= bus.has_data ? ST_WAIT_ADDR : ST_WAIT_CODE;
          end else begin
            bus.overrun <= bus.has_data;
          end
        end
        default: state <= ST_WAIT_CODE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_command_assembler.sv
// Bench: directed vector table, timeout/reset sequences and random traffic against a frame-level model.
module tb_uart_command_assembler;
  localparam int         T    = 8680;
  localparam logic [7:0] MAXC = 8'h06;
  localparam logic [7:0] MAXA = 8'h1F;

  logic clock = 1'b0;
  logic reset = 1'b0;

  uart_command_assembler_if bus();

  uart_command_assembler #(
    .TIMEOUT_CLOCKS(T), .MAX_REQUEST_CODE(MAXC), .MAX_ADDRESS(MAXA)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Frame-level reference: bytes collected so far, idle cycles since the code, hold flags.
  logic [7:0] frame[$];
  int         idle;
  bit         checking, holding;
  logic       m_valid, m_fe, m_ov;
  logic [7:0] m_rc, m_sa;

  typedef struct {
    logic       hd;
    logic [7:0] d;
    logic       rdy;
    logic       v;
    logic [7:0] rc;
    logic [7:0] sa;
    logic       fe;
    logic       ov;
  } vec_t;

  vec_t tbl[26];

  function automatic logic [18:0] outs();
    return {bus.command_valid, bus.request_code, bus.sensor_address, bus.frame_error, bus.overrun};
  endfunction

  function automatic logic [18:0] model_outs();
    return {m_valid, m_rc, m_sa, m_fe, m_ov};
  endfunction

  task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got v=%0b rc=%02h sa=%02h fe=%0b ov=%0b, want v=%0b rc=%02h sa=%02h fe=%0b ov=%0b",
               name, got[18], got[17:10], got[9:2], got[1], got[0],
               exp[18], exp[17:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    frame.delete();
    idle = 0; checking = 0; holding = 0;
    m_valid = 0; m_rc = 0; m_sa = 0; m_fe = 0; m_ov = 0;
  endtask

  task automatic model_step(input logic hd, input logic [7:0] d, input logic rdy);
    m_fe = 0; m_ov = 0;
    if (holding) begin
      if (rdy) begin
        holding = 0; m_valid = 0;
        if (hd) begin frame.delete(); frame.push_back(d); idle = 0; end
      end else if (hd) m_ov = 1;
    end else if (checking) begin
      checking = 0;
      if (hd) m_ov = 1;
      if (frame[0] <= MAXC && frame[1] <= MAXA) begin
        holding = 1; m_valid = 1; m_rc = frame[0]; m_sa = frame[1];
      end else m_fe = 1;
      frame.delete();
    end else if (frame.size() == 1) begin
      if (hd) begin frame.push_back(d); checking = 1; end
      else if (idle == T - 1) begin frame.delete(); m_fe = 1; end
      else idle++;
    end else if (hd) begin
      frame.push_back(d); idle = 0;
    end
  endtask

  task automatic step(input logic hd, input logic [7:0] d, input logic rdy, input string name);
    bus.has_data = hd; bus.data_received = hd ? d : 8'hEE; bus.command_ready = rdy;
    @(posedge clock);
    model_step(hd, d, rdy);
    #1;
    check(name, outs(), model_outs());
  endtask

  initial begin
    int fe_cnt, fe_at, v_cnt;
    tbl = '{
      '{1, 8'h03, 1,  0, 8'h00, 8'h00, 0, 0},
      '{0, 8'h00, 1,  0, 8'h00, 8'h00, 0, 0},
      '{1, 8'h10, 1,  0, 8'h00, 8'h00, 0, 0},
      '{0, 8'h00, 1,  1, 8'h03, 8'h10, 0, 0},
      '{0, 8'h00, 1,  0, 8'h03, 8'h10, 0, 0},
      '{1, 8'h07, 0,  0, 8'h03, 8'h10, 0, 0},
      '{1, 8'h00, 0,  0, 8'h03, 8'h10, 0, 0},
      '{0, 8'h00, 0,  0, 8'h03, 8'h10, 1, 0},
      '{0, 8'h00, 0,  0, 8'h03, 8'h10, 0, 0},
      '{1, 8'h01, 0,  0, 8'h03, 8'h10, 0, 0},
      '{1, 8'h20, 0,  0, 8'h03, 8'h10, 0, 0},
      '{0, 8'h00, 0,  0, 8'h03, 8'h10, 1, 0},
      '{1, 8'h04, 0,  0, 8'h03, 8'h10, 0, 0},
      '{1, 8'h1F, 0,  0, 8'h03, 8'h10, 0, 0},
      '{0, 8'h00, 0,  1, 8'h04, 8'h1F, 0, 0},
      '{1, 8'hAA, 0,  1, 8'h04, 8'h1F, 0, 1},
      '{0, 8'h00, 0,  1, 8'h04, 8'h1F, 0, 0},
      '{1, 8'h02, 1,  0, 8'h04, 8'h1F, 0, 0},
      '{1, 8'h08, 0,  0, 8'h04, 8'h1F, 0, 0},
      '{0, 8'h00, 0,  1, 8'h02, 8'h08, 0, 0},
      '{0, 8'h00, 0,  1, 8'h02, 8'h08, 0, 0},
      '{0, 8'h00, 1,  0, 8'h02, 8'h08, 0, 0},
      '{1, 8'h06, 0,  0, 8'h02, 8'h08, 0, 0},
      '{1, 8'h1F, 0,  0, 8'h02, 8'h08, 0, 0},
      '{1, 8'h33, 0,  1, 8'h06, 8'h1F, 0, 1},
      '{0, 8'h00, 1,  0, 8'h06, 8'h1F, 0, 0}
    };

    bus.has_data = 0; bus.data_received = 0; bus.command_ready = 0;
    model_reset();
    #1 reset = 1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", outs(), 19'd0);
    reset = 0;

    foreach (tbl[i]) begin
      step(tbl[i].hd, tbl[i].d, tbl[i].rdy, $sformatf("tbl%0d_model", i));
      check($sformatf("tbl%0d", i), outs(), {tbl[i].v, tbl[i].rc, tbl[i].sa, tbl[i].fe, tbl[i].ov});
    end

    // Two bytes 100 cycles apart, consumer always ready.
    step(1, 8'h03, 1, "gap_code");
    repeat (99) step(0, 8'h00, 1, "gap_idle");
    step(1, 8'h10, 1, "gap_addr");
    step(0, 8'h00, 1, "gap_check");
    check("gap_latency", outs(), {1'b1, 8'h03, 8'h10, 1'b0, 1'b0});
    step(0, 8'h00, 1, "gap_done");
    check("gap_drop", outs(), {1'b0, 8'h03, 8'h10, 1'b0, 1'b0});

    // Silent line after a code: exactly one frame_error, T cycles after the strobe.
    step(1, 8'h02, 0, "to_code");
    fe_cnt = 0; fe_at = -1;
    for (int k = 1; k <= T + 5; k++) begin
      step(0, 8'h00, 0, "to_idle");
      if (bus.frame_error) begin fe_cnt++; fe_at = k; end
    end
    check_int("to_pulse_count", fe_cnt, 1);
    check_int("to_pulse_cycle", fe_at, T);
    step(1, 8'h01, 0, "to_code2");
    step(1, 8'h05, 0, "to_addr2");
    step(0, 8'h00, 0, "to_check2");
    check("to_recover", outs(), {1'b1, 8'h01, 8'h05, 1'b0, 1'b0});
    step(0, 8'h00, 1, "to_ack");

    // Address arriving on the very cycle the timer expires still wins.
    step(1, 8'h03, 0, "tie_code");
    repeat (T - 1) step(0, 8'h00, 0, "tie_idle");
    step(1, 8'h11, 0, "tie_addr");
    check("tie_no_error", outs(), {1'b0, 8'h01, 8'h05, 1'b0, 1'b0});
    step(0, 8'h00, 0, "tie_check");
    check("tie_cmd", outs(), {1'b1, 8'h03, 8'h11, 1'b0, 1'b0});
    step(0, 8'h00, 1, "tie_ack");

    // Reset mid-frame discards the code; a lone byte afterwards only times out.
    step(1, 8'h03, 0, "rst_code");
    #2 reset = 1;
    #1 check("rst_async", outs(), 19'd0);
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 0;
    step(1, 8'h04, 0, "rst_lone");
    fe_cnt = 0; fe_at = -1; v_cnt = 0;
    for (int k = 1; k <= T + 3; k++) begin
      step(0, 8'h00, 0, "rst_idle");
      if (bus.frame_error) begin fe_cnt++; fe_at = k; end
      if (bus.command_valid) v_cnt++;
    end
    check_int("rst_no_valid", v_cnt, 0);
    check_int("rst_fe_count", fe_cnt, 1);
    check_int("rst_fe_cycle", fe_at, T);

    for (int n = 0; n < 3000; n++) begin
      logic       hd, rdy;
      logic [7:0] d;
      hd  = ($urandom_range(0, 99) < 35);
      rdy = ($urandom_range(0, 99) < 40);
      d   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8'h22));
      step(hd, d, rdy, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
